// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
//   Arbitrated, handshaked sequencer for the RTC multiplexed address/data bus.
//   One requester at a time is granted. Its address is put on the bus, and then
//   either its write data or a read, with configurable setup, strobe and hold
//   phases, followed by an idle gap.
//
// Ports
//   clk, Reset            clock and synchronous active-high reset
//   req/req_rd            per-requester request (held until done) and direction (1 = read)
//   req_addr/req_wdata    packed per-requester address / write data, slot i = [i*DW +: DW]
//   grant                 one-hot owner of the running transaction
//   done                  one-cycle completion pulse
//   rdata/rdata_valid     read data (held until the next read) and its one-cycle valid
//   busy                  sequencer is not idle
//   cs_n/rd_n/wr_n/ad_n   RTC strobes, active low (ad_n low = address phase)
//   bus_dout/bus_oe       bus drive value and tristate enable
//   bus_din               bus input, sampled during the read strobe
//
// Timing: grant is registered on the arbitration edge. Every pin/status output
// is registered from the current state, so the pins lag the state by one cycle.
// Grant appears in cycle 0, the address phase is on the pins from cycle 1, and
// done appears at cycle 1 + 2*(T_SU+T_PW+T_HD).
module rtc_bus_sequencer #(
    parameter int NREQ   = 4,
    parameter int DW     = 8,
    parameter int T_SU   = 1,
    parameter int T_PW   = 2,
    parameter int T_HD   = 1,
    parameter int T_GAP  = 2,
    parameter int ARB_RR = 0
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ*DW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      grant,
    output logic                 done,
    output logic [DW-1:0]        rdata,
    output logic                 rdata_valid,
    output logic                 busy,
    output logic                 cs_n,
    output logic                 rd_n,
    output logic                 wr_n,
    output logic                 ad_n,
    output logic [DW-1:0]        bus_dout,
    output logic                 bus_oe,
    input  logic [DW-1:0]        bus_din
);

    localparam int T_MAX_A = (T_SU > T_PW) ? T_SU : T_PW;
    localparam int T_MAX_B = (T_HD > T_GAP) ? T_HD : T_GAP;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CW      = $clog2(T_MAX + 1);
    localparam int PTRW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] CNT_SU  = CW'(T_SU - 1);
    localparam logic [CW-1:0] CNT_PW  = CW'(T_PW - 1);
    localparam logic [CW-1:0] CNT_HD  = CW'(T_HD - 1);
    localparam logic [CW-1:0] CNT_GAP = CW'(T_GAP - 1);

    typedef enum logic [2:0] {IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, GAP} state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [PTRW-1:0]     ptr_reg, ptr_next;
    logic [DW-1:0]       addr_lat_reg, addr_lat_next;
    logic [DW-1:0]       wdata_lat_reg, wdata_lat_next;
    logic                rd_lat_reg, rd_lat_next;
    logic                cap_en_reg, cap_en_next;
    logic [DW-1:0]       cap_reg, cap_next;
    logic [NREQ-1:0]     grant_reg, grant_next;
    logic                done_reg, done_next;
    logic [DW-1:0]       rdata_reg, rdata_next;
    logic                rdata_valid_reg, rdata_valid_next;
    logic                busy_reg, busy_next;
    logic                cs_n_reg, cs_n_next;
    logic                rd_n_reg, rd_n_next;
    logic                wr_n_reg, wr_n_next;
    logic                ad_n_reg, ad_n_next;
    logic [DW-1:0]       bus_dout_reg, bus_dout_next;
    logic                bus_oe_reg, bus_oe_next;

    logic                win_found;
    logic [PTRW-1:0]     win_idx;
    logic                cnt_zero;
    logic                in_addr, in_data;
    int                  idx;

    logic [DW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*DW +: DW];
        assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end

    // Scan from the highest offset down, so the last hit is the lowest offset.
    // In fixed mode the offset is the index itself; in round-robin mode it is
    // measured from the pointer and wraps at NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (ARB_RR != 0) ? (int'(ptr_reg) + i) : i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[PTRW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PTRW'(idx);
            end
        end
    end

    assign cnt_zero = (cnt_reg == '0);
    assign in_addr  = (state_reg == A_SU) || (state_reg == A_PW) || (state_reg == A_HD);
    assign in_data  = (state_reg == D_SU) || (state_reg == D_PW) || (state_reg == D_HD);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_zero ? cnt_reg : cnt_reg - CW'(1);
        ptr_next       = ptr_reg;
        addr_lat_next  = addr_lat_reg;
        wdata_lat_next = wdata_lat_reg;
        rd_lat_next    = rd_lat_reg;
        grant_next     = grant_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (win_found) begin
                    state_next     = A_SU;
                    cnt_next       = CNT_SU;
                    addr_lat_next  = addr_arr[win_idx];
                    wdata_lat_next = wdata_arr[win_idx];
                    rd_lat_next    = req_rd[win_idx];
                    grant_next     = NREQ'(1) << win_idx;
                    if (ARB_RR != 0) begin
                        ptr_next = (win_idx == PTRW'(NREQ - 1)) ? '0 : win_idx + PTRW'(1);
                    end
                end
            end
            A_SU: if (cnt_zero) begin state_next = A_PW; cnt_next = CNT_PW; end
            A_PW: if (cnt_zero) begin state_next = A_HD; cnt_next = CNT_HD; end
            A_HD: if (cnt_zero) begin state_next = D_SU; cnt_next = CNT_SU; end
            D_SU: if (cnt_zero) begin state_next = D_PW; cnt_next = CNT_PW; end
            D_PW: if (cnt_zero) begin state_next = D_HD; cnt_next = CNT_HD; end
            D_HD: if (cnt_zero) begin state_next = GAP;  cnt_next = CNT_GAP; end
            GAP: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pin and status values for the next cycle, derived from the current state.
    always_comb begin
        cs_n_next        = ~(in_addr | in_data);
        ad_n_next        = ~in_addr;
        wr_n_next        = ~((state_reg == A_PW) || ((state_reg == D_PW) && !rd_lat_reg));
        rd_n_next        = ~((state_reg == D_PW) && rd_lat_reg);
        bus_oe_next      = in_addr | (in_data & ~rd_lat_reg);
        bus_dout_next    = '0;
        if (in_addr) begin
            bus_dout_next = addr_lat_reg;
        end else if (in_data && !rd_lat_reg) begin
            bus_dout_next = wdata_lat_reg;
        end
        busy_next        = (state_reg != IDLE);
        done_next        = (state_reg == GAP) && (cnt_reg == CNT_GAP);
        rdata_valid_next = done_next && rd_lat_reg;
        rdata_next       = rdata_valid_next ? cap_reg : rdata_reg;
        // The capture strobe trails the last D_PW state by one cycle, so
        // bus_din is sampled in the last cycle rd_n is low on the pins.
        cap_en_next      = (state_reg == D_PW) && cnt_zero && rd_lat_reg;
        cap_next         = cap_en_reg ? bus_din : cap_reg;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            ptr_reg         <= '0;
            addr_lat_reg    <= '0;
            wdata_lat_reg   <= '0;
            rd_lat_reg      <= 1'b0;
            cap_en_reg      <= 1'b0;
            cap_reg         <= '0;
            grant_reg       <= '0;
            done_reg        <= 1'b0;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            cs_n_reg        <= 1'b1;
            rd_n_reg        <= 1'b1;
            wr_n_reg        <= 1'b1;
            ad_n_reg        <= 1'b1;
            bus_dout_reg    <= '0;
            bus_oe_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            ptr_reg         <= ptr_next;
            addr_lat_reg    <= addr_lat_next;
            wdata_lat_reg   <= wdata_lat_next;
            rd_lat_reg      <= rd_lat_next;
            cap_en_reg      <= cap_en_next;
            cap_reg         <= cap_next;
            grant_reg       <= grant_next;
            done_reg        <= done_next;
            rdata_reg       <= rdata_next;
            rdata_valid_reg <= rdata_valid_next;
            busy_reg        <= busy_next;
            cs_n_reg        <= cs_n_next;
            rd_n_reg        <= rd_n_next;
            wr_n_reg        <= wr_n_next;
            ad_n_reg        <= ad_n_next;
            bus_dout_reg    <= bus_dout_next;
            bus_oe_reg      <= bus_oe_next;
        end
    end

    assign grant       = grant_reg;
    assign done        = done_reg;
    assign rdata       = rdata_reg;
    assign rdata_valid = rdata_valid_reg;
    assign busy        = busy_reg;
    assign cs_n        = cs_n_reg;
    assign rd_n        = rd_n_reg;
    assign wr_n        = wr_n_reg;
    assign ad_n        = ad_n_reg;
    assign bus_dout    = bus_dout_reg;
    assign bus_oe      = bus_oe_reg;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer. Two instances run concurrently:
//   dut0: default timing, fixed priority
//   dut1: T_SU=2, T_PW=3, T_HD=1, T_GAP=1, round-robin
// Each instance has a driver, which issues transactions and pushes the
// predicted response, and a monitor, which watches the pins and pops and
// compares on grant and done.
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] w;
        logic       rd;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] v;
    } exp_t;

    task automatic check(input string name, input int blk, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, blk, act, want);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int SU  = (gi == 0) ? 1 : 2;
        localparam int PWC = (gi == 0) ? 2 : 3;
        localparam int HD  = 1;
        localparam int GP  = (gi == 0) ? 2 : 1;
        localparam int RR  = gi;
        localparam int PH  = SU + PWC + HD;
        localparam int LAT = 1 + 2 * PH;
        localparam int NT  = 40;

        logic        rst;
        logic [3:0]  req, req_rd, grant;
        logic [31:0] req_addr, req_wdata;
        logic [7:0]  bus_din, rdata, bus_dout;
        logic        done, rdata_valid, busy, cs_n, rd_n, wr_n, ad_n, bus_oe;

        rtc_bus_sequencer #(
            .NREQ(4), .DW(8), .T_SU(SU), .T_PW(PWC), .T_HD(HD), .T_GAP(GP), .ARB_RR(RR)
        ) u_dut (
            .clk(clk), .Reset(rst), .req(req), .req_rd(req_rd),
            .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
            .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .cs_n(cs_n),
            .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n), .bus_dout(bus_dout),
            .bus_oe(bus_oe), .bus_din(bus_din)
        );

        exp_t       q[$];
        int         ptr;
        logic [7:0] cur_v;
        bit         fin;

        // Reference arbitration: lowest set index, or first set index at or
        // after the pointer when round-robin, and the pointer then moves past it.
        function automatic int arb(input logic [3:0] m);
            int w;
            w = -1;
            for (int off = 3; off >= 0; off--) begin
                int j;
                j = (RR != 0) ? (ptr + off) % 4 : off;
                if (((m >> j) & 4'd1) != 4'd0) w = j;
            end
            if (RR != 0 && w >= 0) ptr = (w + 1) % 4;
            return w;
        endfunction

        task automatic issue(input logic [3:0] m, input logic [3:0] rdm,
                             input logic [31:0] a, input logic [31:0] d, input logic [7:0] v);
            exp_t e;
            int   w;
            w = arb(m);
            req = m; req_rd = rdm; req_addr = a; req_wdata = d; cur_v = v;
            e.w  = 2'(w);
            e.rd = rdm[2'(w)];
            e.a  = 8'(a >> (8 * w));
            e.d  = 8'(d >> (8 * w));
            e.v  = v;
            q.push_back(e);
        endtask

        task automatic chk_reset();
            check("rst_strobes", gi, 32'({cs_n, rd_n, wr_n, ad_n}), 32'h0000_000F);
            check("rst_ctrl", gi, 32'({grant, done, rdata_valid, busy, bus_oe}), 32'h0);
            check("rst_data", gi, 32'({rdata, bus_dout}), 32'h0);
        endtask

        // Waits for done; once the grant is seen, the request inputs are
        // scrambled to show that the running transaction ignores them.
        task automatic wait_done(input bit scr);
            bit got, scrambled;
            got = 1'b0;
            scrambled = 1'b0;
            for (int c = 0; c < LAT + 40 && !got; c++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                end else if (scr && !scrambled && grant != 4'd0) begin
                    req = 4'($urandom); req_rd = 4'($urandom);
                    req_addr = $urandom; req_wdata = $urandom;
                    scrambled = 1'b1;
                end
            end
            check("done_seen", gi, 32'(got), 32'd1);
        endtask

        // Bus model: drive the read value while rd_n is low, junk otherwise.
        initial begin
            bus_din = 8'h00;
            forever begin
                @(negedge clk);
                bus_din = (rd_n == 1'b0) ? cur_v : 8'($urandom);
            end
        end

        // Driver
        initial begin
            logic [3:0]  m, rdm;
            logic [31:0] a, d;
            logic [7:0]  v;
            bit          got;
            rst = 1'b1; req = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
            cur_v = '0; ptr = 0; fin = 1'b0;
            repeat (3) @(negedge clk);
            chk_reset();
            rst = 1'b0;
            repeat (4) @(negedge clk);
            check("idle_no_req", gi, 32'({grant, busy, cs_n}), 32'h1);

            // Reset in the middle of a write: no done for the aborted transaction.
            issue(4'b0100, 4'b0000, 32'h00AA_0000, 32'h0055_0000, 8'h00);
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                got = (grant != 4'd0);
            end
            check("abort_grant_seen", gi, 32'(got), 32'd1);
            repeat (6) @(negedge clk);
            rst = 1'b1;
            req = '0;
            @(negedge clk);
            chk_reset();
            q.delete();
            ptr = 0;
            @(negedge clk);
            rst = 1'b0;
            repeat (2 * LAT) @(negedge clk);

            for (int k = 0; k < NT; k++) begin
                m = 4'($urandom_range(1, 15)); rdm = 4'($urandom);
                a = $urandom; d = $urandom; v = 8'($urandom);
                if (k < 5) begin
                    m = 4'b1111;
                end else if (k == 5) begin
                    m = 4'b0100; rdm = 4'b0000; a = 32'h0021_0000; d = 32'h0045_0000;
                end else if (k == 6) begin
                    m = 4'b0010; rdm = 4'b0010; a = 32'h0000_2200; v = 8'h37;
                end
                issue(m, rdm, a, d, v);
                wait_done(k >= 7);
            end
            req = '0;
            repeat (LAT) @(negedge clk);
            fin = 1'b1;
        end

        // Monitor
        initial begin
            exp_t       e;
            bit         armed, have_fall, rise, fall;
            logic [3:0] prev_g;
            int         t, glen, idle_len, na, nwa, nd, nwd, nrd, nbad;
            logic [7:0] last_rd;
            armed = 0; have_fall = 0; prev_g = '0; last_rd = '0;
            t = 0; glen = 0; idle_len = 0; na = 0; nwa = 0; nd = 0; nwd = 0; nrd = 0; nbad = 0;
            e = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    armed = 0; have_fall = 0; prev_g = '0; last_rd = '0;
                end else begin
                    rise = (grant != 4'd0) && (prev_g == 4'd0);
                    fall = (grant == 4'd0) && (prev_g != 4'd0);
                    if (!armed) begin
                        check("idle_pins", gi, 32'({cs_n, rd_n, wr_n, bus_oe}), 32'hE);
                    end
                    if (rise) begin
                        if (q.size() == 0) begin
                            check("unexpected_grant", gi, 32'(grant), 32'h0);
                        end else begin
                            e = q[0];
                            check("grant", gi, 32'(grant), 32'(4'd1 << e.w));
                            if (have_fall) check("regrant_gap", gi, 32'(idle_len), 32'd1);
                            armed = 1;
                        end
                        t = 0; glen = 1;
                        na = 0; nwa = 0; nd = 0; nwd = 0; nrd = 0; nbad = 0;
                    end else begin
                        t++;
                        if (grant != 4'd0) glen++;
                    end
                    if (armed && !cs_n) begin
                        if (!ad_n) begin
                            na++;
                            if (!wr_n) nwa++;
                            if (!bus_oe || bus_dout != e.a || !rd_n) nbad++;
                        end else begin
                            nd++;
                            if (!wr_n) nwd++;
                            if (!rd_n) nrd++;
                            if (e.rd ? bus_oe : (!bus_oe || bus_dout != e.d)) nbad++;
                        end
                    end
                    if (done) begin
                        if (!armed || q.size() == 0) begin
                            check("unexpected_done", gi, 32'(done), 32'h0);
                        end else begin
                            e = q.pop_front();
                            check("latency", gi, 32'(t), 32'(LAT));
                            check("addr_cycles", gi, 32'(na), 32'(PH));
                            check("addr_wr_cycles", gi, 32'(nwa), 32'(PWC));
                            check("data_cycles", gi, 32'(nd), 32'(PH));
                            check("data_wr_cycles", gi, 32'(nwd), e.rd ? 32'd0 : 32'(PWC));
                            check("data_rd_cycles", gi, 32'(nrd), e.rd ? 32'(PWC) : 32'd0);
                            check("bus_values", gi, 32'(nbad), 32'd0);
                            check("rdata_valid", gi, 32'(rdata_valid), 32'(e.rd));
                            if (e.rd) last_rd = e.v;
                            check("rdata", gi, 32'(rdata), 32'(last_rd));
                            check("busy_at_done", gi, 32'(busy), 32'd1);
                            armed = 0;
                        end
                    end
                    if (rdata_valid && !done) begin
                        check("rdata_valid_alone", gi, 32'(rdata_valid), 32'h0);
                    end
                    if (fall) begin
                        check("grant_len", gi, 32'(glen), 32'(LAT - 1 + GP));
                        have_fall = 1;
                    end
                    if (grant == 4'd0) idle_len = fall ? 1 : idle_len + 1;
                    prev_g = grant;
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < 20000 && !(g_dut[0].fin && g_dut[1].fin); c++) begin
            @(negedge clk);
        end
        check("all_finished", 0, 32'(g_dut[0].fin && g_dut[1].fin), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
